// File: rtl/bus_cycle_seq_if.sv
// Pin-side bundle for bus_cycle_seq: cycle descriptor from the decoder, bus handshakes, and
// the status/strobe/enable outputs toward the pin ring.
interface bus_cycle_seq_if #(
    parameter int unsigned MAXCYC = 4,
    parameter int unsigned CNTW   = 3
);
    logic              cyc_load;
    logic              cyc_go6;
    logic [CNTW-1:0]   cyc_n;
    logic [MAXCYC-1:0] cyc_wr;
    logic [MAXCYC-1:0] cyc_dat;
    logic              cyc_io;
    logic              cyc_bid;
    logic              cyc_halt;
    logic              ready;
    logic              hold;
    logic              intr;

    logic              ale;
    logic              s0;
    logic              s1;
    logic              io_m_;
    logic              rd_;
    logic              wr_;
    logic              inta_;
    logic              ctl_oe;
    logic              hlda;
    logic              addr_oe_h;
    logic              addr_oe_l;
    logic              data_oe;
    logic              ir_wr;
    logic              tmp_wr;
    logic              pc_inc;
    logic              use_dat;
    logic              wait_err;
    logic [9:0]        tstate;

    modport master (
        output cyc_load, cyc_go6, cyc_n, cyc_wr, cyc_dat, cyc_io, cyc_bid, cyc_halt,
        output ready, hold, intr,
        input  ale, s0, s1, io_m_, rd_, wr_, inta_, ctl_oe, hlda, addr_oe_h, addr_oe_l,
        input  data_oe, ir_wr, tmp_wr, pc_inc, use_dat, wait_err, tstate
    );

    modport slave (
        input  cyc_load, cyc_go6, cyc_n, cyc_wr, cyc_dat, cyc_io, cyc_bid, cyc_halt,
        input  ready, hold, intr,
        output ale, s0, s1, io_m_, rd_, wr_, inta_, ctl_oe, hlda, addr_oe_h, addr_oe_l,
        output data_oe, ir_wr, tmp_wr, pc_inc, use_dat, wait_err, tstate
    );
endinterface

// File: rtl/bus_cycle_seq.sv
// 8085-class machine-cycle sequencer: one-hot T-state FSM, follow-on cycle queue, HOLD/HLDA,
// INA and halt exit. Define BUS_WAIT_TIMEOUT_EN to bound consecutive TW states by WAITMAX.
module bus_cycle_seq #(
    parameter int unsigned MAXCYC  = 4,
    parameter int unsigned CNTW    = 3,
    parameter int unsigned WAITMAX = 15
) (
    input logic            clk_,
    input logic            rst_,
    bus_cycle_seq_if.slave bus
);
    typedef enum logic [9:0] {
        StTr = 10'b00_0000_0001,
        StT1 = 10'b00_0000_0010,
        StT2 = 10'b00_0000_0100,
        StT3 = 10'b00_0000_1000,
        StT4 = 10'b00_0001_0000,
        StT5 = 10'b00_0010_0000,
        StT6 = 10'b00_0100_0000,
        StTh = 10'b00_1000_0000,
        StTw = 10'b01_0000_0000,
        StTt = 10'b10_0000_0000
    } state_e;

    typedef enum logic [2:0] {CyOf, CyIna, CyBih, CyBid, CyMr, CyMw, CyDr, CyDw} cyc_e;

    state_e            r_state, w_state_d;
    cyc_e              r_cyc, w_cyc_d;
    logic [CNTW-1:0]   r_rem, w_rem_d;
    logic [MAXCYC-1:0] r_wr_q, w_wr_d;
    logic [MAXCYC-1:0] r_dat_q, w_dat_d;
    logic              r_io_q, w_io_d;
    logic              r_bid_q, w_bid_d;
    logic              r_halt_q, w_halt_d;
    logic              r_int_pend, w_int_d;
    logic              w_bnd, w_tt_int, w_int_cur, w_load, w_fo_t3;
    logic              w_wait_hit, w_follow, w_no_wait;

    assign w_follow  = r_cyc inside {CyBid, CyMr, CyMw, CyDr, CyDw};
    assign w_no_wait = r_cyc inside {CyBid, CyBih};

`ifdef BUS_WAIT_TIMEOUT_EN
    logic [7:0] r_wait_cnt;

    // Hit on the WAITMAX-th consecutive TW; that TW is the last one.
    assign w_wait_hit   = (r_state == StTw) && (r_wait_cnt == 8'(WAITMAX - 1));
    assign bus.wait_err = w_wait_hit;

    always_ff @(posedge clk_ or posedge rst_) begin
        if (rst_) begin
            r_wait_cnt <= '0;
        end else if (r_state == StTw && w_state_d == StTw) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end else begin
            r_wait_cnt <= '0;
        end
    end
`else
    logic w_unused_waitmax;

    assign w_wait_hit       = 1'b0;
    assign bus.wait_err     = 1'b0;
    assign w_unused_waitmax = (WAITMAX != 0);
`endif

    always_comb begin
        w_state_d = r_state;
        w_bnd     = 1'b0;
        w_tt_int  = 1'b0;
        unique case (r_state)
            StTr: w_state_d = StT1;
            StT1: w_state_d = (r_cyc == CyBih) ? StTt : StT2;
            StT2, StTw: begin
                w_state_d = (bus.ready || w_no_wait || w_wait_hit) ? StT3 : StTw;
            end
            StT3: begin
                if (r_cyc inside {CyOf, CyIna}) w_state_d = StT4;
                else w_bnd = 1'b1;
            end
            StT4: begin
                if (bus.cyc_go6) w_state_d = StT5;
                else w_bnd = 1'b1;
            end
            StT5: w_state_d = StT6;
            StT6: w_bnd = 1'b1;
            StTh: begin
                if (!bus.hold) w_state_d = r_halt_q ? StTt : StT1;
            end
            StTt: begin
                if (bus.hold) begin
                    w_state_d = StTh;
                end else if (bus.intr) begin
                    w_state_d = StT1;
                    w_tt_int  = 1'b1;
                end
            end
            default: w_state_d = StTr;
        endcase
        // HOLD is only honoured between machine cycles.
        if (w_bnd) w_state_d = bus.hold ? StTh : StT1;
    end

    always_comb begin
        w_rem_d  = r_rem;
        w_wr_d   = r_wr_q;
        w_dat_d  = r_dat_q;
        w_io_d   = r_io_q;
        w_bid_d  = r_bid_q;
        w_halt_d = r_halt_q;
        w_fo_t3  = (r_state == StT3) && w_follow;
        w_load   = bus.cyc_load && ((w_state_d == StT4 && !bus.cyc_go6) || w_state_d == StT6);
        if (w_fo_t3) begin
            w_rem_d = r_rem - CNTW'(1);
            w_wr_d  = r_wr_q >> 1;
            w_dat_d = r_dat_q >> 1;
        end
        if (w_load) begin
            w_rem_d  = bus.cyc_n;
            w_wr_d   = bus.cyc_wr;
            w_dat_d  = bus.cyc_dat;
            w_io_d   = bus.cyc_io;
            w_bid_d  = bus.cyc_bid;
            w_halt_d = bus.cyc_halt;
        end
        if (w_tt_int) w_halt_d = 1'b0;

        w_int_cur = r_int_pend || w_tt_int || (w_bnd && w_rem_d == '0 && bus.intr);

        // Classify the next cycle from post-edge queue state so T1 sees it directly.
        w_cyc_d = CyOf;
        if (w_rem_d == '0) begin
            if (w_int_cur) w_cyc_d = CyIna;
            else if (w_halt_d) w_cyc_d = CyBih;
            else w_cyc_d = CyOf;
        end else if (w_bid_d) begin
            w_cyc_d = CyBid;
        end else begin
            unique case ({w_io_d, w_wr_d[0]})
                2'b00: w_cyc_d = CyMr;
                2'b01: w_cyc_d = CyMw;
                2'b10: w_cyc_d = CyDr;
                2'b11: w_cyc_d = CyDw;
            endcase
        end

        w_int_d = w_int_cur;
        if (w_state_d == StT1 && w_cyc_d == CyIna) w_int_d = 1'b0;
    end

    always_ff @(posedge clk_ or posedge rst_) begin
        if (rst_) begin
            r_state    <= StTr;
            r_cyc      <= CyOf;
            r_rem      <= '0;
            r_wr_q     <= '0;
            r_dat_q    <= '0;
            r_io_q     <= 1'b0;
            r_bid_q    <= 1'b0;
            r_halt_q   <= 1'b0;
            r_int_pend <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_rem      <= w_rem_d;
            r_wr_q     <= w_wr_d;
            r_dat_q    <= w_dat_d;
            r_io_q     <= w_io_d;
            r_bid_q    <= w_bid_d;
            r_halt_q   <= w_halt_d;
            r_int_pend <= w_int_d;
            if (w_state_d == StT1) r_cyc <= w_cyc_d;
        end
    end

    assign bus.tstate = r_state;

    always_comb begin
        bus.ale       = 1'b0;
        bus.s0        = 1'b0;
        bus.s1        = 1'b0;
        bus.io_m_     = 1'b0;
        bus.rd_       = 1'b1;
        bus.wr_       = 1'b1;
        bus.inta_     = 1'b1;
        bus.ctl_oe    = 1'b0;
        bus.hlda      = 1'b0;
        bus.addr_oe_h = 1'b0;
        bus.addr_oe_l = 1'b0;
        bus.data_oe   = 1'b0;
        bus.ir_wr     = 1'b0;
        bus.tmp_wr    = 1'b0;
        bus.pc_inc    = 1'b0;
        bus.use_dat   = 1'b0;
        unique case (r_state)
            StT1, StT2, StTw, StT3: begin
                bus.ctl_oe    = 1'b1;
                bus.addr_oe_h = 1'b1;
                unique case (r_cyc)
                    CyOf:  {bus.io_m_, bus.s1, bus.s0} = 3'b011;
                    CyIna: {bus.io_m_, bus.s1, bus.s0} = 3'b111;
                    CyBih: {bus.io_m_, bus.s1, bus.s0} = 3'b000;
                    CyBid: {bus.io_m_, bus.s1, bus.s0} = 3'b010;
                    CyMr:  {bus.io_m_, bus.s1, bus.s0} = 3'b010;
                    CyMw:  {bus.io_m_, bus.s1, bus.s0} = 3'b001;
                    CyDr:  {bus.io_m_, bus.s1, bus.s0} = 3'b110;
                    CyDw:  {bus.io_m_, bus.s1, bus.s0} = 3'b101;
                endcase
                bus.use_dat = w_follow && r_dat_q[0];
                if (r_state == StT1) begin
                    bus.addr_oe_l = 1'b1;
                    bus.ale       = !w_no_wait;
                end else begin
                    bus.rd_     = !(r_cyc inside {CyOf, CyMr, CyDr});
                    bus.wr_     = !(r_cyc inside {CyMw, CyDw});
                    bus.inta_   = !(r_cyc == CyIna);
                    bus.data_oe = r_cyc inside {CyMw, CyDw};
                end
                if (r_state == StT2) begin
                    bus.pc_inc = (r_cyc == CyOf) || ((r_cyc inside {CyMr, CyMw}) && !r_dat_q[0]);
                end
                if (r_state == StT3) begin
                    bus.ir_wr  = r_cyc inside {CyOf, CyIna};
                    bus.tmp_wr = w_follow;
                end
            end
            StT4, StT5, StT6: begin
                bus.ctl_oe    = 1'b1;
                bus.addr_oe_h = 1'b1;
                bus.s1        = 1'b1;
                bus.s0        = 1'b1;
            end
            StTh:    bus.hlda = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: doc/bus_cycle_seq.md
Name: bus_cycle_seq

Overview:
- Parametrised machine-cycle sequencer for the 8085-class core.
- Steps the one-hot T-state machine (TR, T1-T6, TW, TH, TT) and issues status and strobe pins for each machine cycle.
- Queues up to MAXCYC follow-on machine cycles per instruction.
- Beyond the earlier controller, it adds a HOLD/HLDA handshake at any machine-cycle boundary, interrupt-acknowledge (INA) cycles, interrupt exit from halt and a bounded wait-state counter.
- Sits between the instruction decoder/alureg and the pin ring.

Parameters:
- MAXCYC, 4, max follow-on machine cycles per instruction (mask width); legal range 1..8.
- CNTW, 3, width of cycle-count input and remaining-cycle counter; must hold MAXCYC.
- WAITMAX, 15, TW states allowed before wait timeout; 1..255.

Ports:
- clk_ in 1: clock, all state changes on posedge.
- rst_ in 1: asynchronous reset, active-high.
- cyc_load in 1: load a cycle descriptor; sampled on entry to T4 (when cyc_go6=0) or on entry to T6.
- cyc_go6 in 1: opcode fetch takes T4-T6.
- cyc_n in CNTW: number of follow-on cycles, 0..MAXCYC.
- cyc_wr in MAXCYC: per-cycle write flag; bit0 is the first cycle.
- cyc_dat in MAXCYC: per-cycle "use data address" flag.
- cyc_io in 1: follow-on reads/writes are device cycles.
- cyc_bid in 1: follow-on cycles are bus-idle (DAD).
- cyc_halt in 1: instruction is HLT.
- ready in 1: READY pin.
- hold in 1: HOLD pin.
- intr in 1: interrupt request, level.
- ale out 1: ALE.
- s0, s1, io_m_ out 1 each: status pins.
- rd_, wr_, inta_ out 1 each: strobes, active-low.
- ctl_oe out 1: pin-ring enable for io_m_/rd_/wr_.
- hlda out 1: hold acknowledge.
- addr_oe_h, addr_oe_l, data_oe out 1 each: bus drive enables.
- ir_wr out 1: write instruction register.
- tmp_wr out 1: write temp register.
- pc_inc out 1: increment PC.
- use_dat out 1: current cycle uses data address.
- wait_err out 1: one-cycle timeout pulse.
- tstate out 10: one-hot {TT,TW,TH,T6,T5,T4,T3,T2,T1,TR}.

Behaviour:
- Reset: tstate=TR, remaining count 0, masks 0, int/halt latches 0. Outputs in reset: ale=0, rd_=wr_=inta_=1, ctl_oe=0, hlda=0, all oe/wr/inc=0, wait_err=0.
- Cycle type latched on T1 entry, priority order:
  - rem==0 & int_pend: INA (io_m_=1, s1=1, s0=1, inta_ strobes).
  - rem==0 & halt_q: BIH (s1=0, s0=0, no strobe); T1 then goes to TT.
  - rem==0: OF (io_m_=0, s1=1, s0=1, rd_ strobes).
  - bid_q: BID (io_m_=0, s1=1, s0=0, no strobe).
  - otherwise MR / MW / DR / DW from {io_q, wr_q[0]}: MR 0/10, MW 0/01, DR 1/10, DW 1/01.
- Strobes are low in T2/TW/T3 only. ale=1 in T1 except BID/BIH. addr_oe_h=1 in T1-T6. addr_oe_l=1 in T1 only. data_oe=1 in T2/TW/T3 of write cycles.
- T4-T6: io_m_=0, s1=1, s0=1; strobes high.
- TR/TH/TT: ctl_oe=0; all oe off.
- Transitions:
  - TR -> T1.
  - T1 -> TT if BIH, else T2.
  - T2/TW -> T3 if ready or BID/BIH, else TW.
  - T3 -> T4 if OF/INA, else boundary.
  - T4 -> T5 if cyc_go6, else boundary.
  - T5 -> T6.
  - T6 -> boundary.
  - boundary = TH if hold, else T1.
  - TH -> T1 when hold=0 (TT if halt_q set).
  - TT -> TH if hold; else T1 if intr (clear halt_q, set int_pend).
- intr sampled at boundaries with rem==0 sets int_pend; INA T1 entry clears it.
- Counting: T3 of a follow-on cycle decrements rem and shifts wr/dat masks right with zero fill. cyc_load overwrites all queued state; load with cyc_n=0 is legal.
- ir_wr = T3 of OF/INA. tmp_wr = T3 of follow-on cycle. pc_inc = T2 of OF, or T2 of MR/MW with dat_q[0]=0 and not BID. use_dat = dat_q[0] in follow-on cycles.
- hlda=1 in every TH cycle; hold asserted mid-cycle is deferred to the boundary.
- Reset mid-cycle returns to TR immediately (async) and discards queue and latches.

Optional Feature:
- BUS_WAIT_TIMEOUT_EN defined: wait counter (8b) counts consecutive TW. When it reaches WAITMAX, next state is T3 regardless of ready, wait_err=1 for that one cycle, and counter clears on leaving TW.
- Undefined: TW persists until ready; wait_err tied 0.

Test Plan:
- Release rst_ with ready=1, cyc_load=1, cyc_n=2, cyc_wr=2'b10, cyc_io=0 -> OF (T1-T4), then MR (s=10), then MW (s=01, data_oe in T2/T3); tmp_wr pulses twice, then OF again.
- ready=0 for 3 clocks during MR T2 -> exactly 3 TW states, rd_ held low, T3 on the clock after ready=1.
- hold=1 asserted in T2 of OF with cyc_go6=1 -> completes T3-T6, enters TH with hlda=1, ctl_oe=0; hold=0 -> next state T1.
- cyc_halt=1 -> BIH T1 -> TT; intr=1 -> T1 INA with inta_ low in T2/T3, rd_ high, s=11, io_m_=1.
- Asynchronous rst_ pulse in MW T2 with rem=1 -> tstate=TR same edge, wr_=1, next T1 is OF.
- With BUS_WAIT_TIMEOUT_EN, WAITMAX=4, ready held 0 -> 4 TW states, wait_err one-cycle pulse, then T3.
